// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if: requester, adder and response signals of the shared-adder arbiter.
// master = requesters plus adder environment, slave = the arbiter.
interface adder_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4
);
  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              dp_valid;
  logic [W-1:0]      dp_a;
  logic [W-1:0]      dp_b;
  logic [W-1:0]      dp_sum;
  logic              dp_carry;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_carry;
  logic              busy;

  modport master (
    output req, a_in, b_in, dp_sum, dp_carry,
    input  gnt, dp_valid, dp_a, dp_b, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
  );

  modport slave (
    input  req, a_in, b_in, dp_sum, dp_carry,
    output gnt, dp_valid, dp_a, dp_b, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin arbiter/sequencer sharing one W-bit adder among NREQ
// requesters. One operation in flight; result returned DP_LAT cycles after issue, tagged
// with the requester index.
// Optional build macro ADDER_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins,
// pointer held at 0). Default build is round-robin.
module adder_share_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned W      = 4,
  parameter int unsigned DP_LAT = 1
) (
  input logic                  clk,
  input logic                  rst,
  adder_share_arbiter_if.slave bus
);
  localparam int unsigned ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WAIT, RESP} state_t;

  state_t          state_q;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] cur_id_q;
  logic [3:0]      cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic            dp_valid_q;
  logic [W-1:0]    dp_a_q, dp_b_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [W-1:0]    rsp_sum_q;
  logic            rsp_carry_q;
  logic            busy_q;

  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic [ID_W-1:0] base;
  logic            win_found;
  logic [ID_W-1:0] win_id;
  logic            latch;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = bus.a_in[g*W +: W];
    assign b_arr[g] = bus.b_in[g*W +: W];
  end

  // Pointer update and arbitration search (first high req from the pointer, with wrap)
  always_comb begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
    ptr_d = ptr_q;
`else
    // In RESP the search already starts at cur_id+1, i.e. the pointer being written now
    ptr_d = (state_q == RESP) ?
            ((cur_id_q == ID_W'(NREQ - 1)) ? '0 : cur_id_q + ID_W'(1)) : ptr_q;
`endif
    base      = ptr_d;
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_found && bus.req[ID_W'((32'(base) + i) % NREQ)]) begin
        win_found = 1'b1;
        win_id    = ID_W'((32'(base) + i) % NREQ);
      end
    end
    latch = win_found && ((state_q == IDLE) || (state_q == RESP));
  end

  // Sequencer FSM with registered outputs; issue period is DP_LAT+1 cycles
  // (GRANT, DP_LAT-1 WAIT cycles, RESP which re-arbitrates)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cur_id_q    <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      dp_valid_q  <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt_q       <= '0;
      dp_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      ptr_q       <= ptr_d;
      case (state_q)
        IDLE: ;
        GRANT: begin
          if (DP_LAT == 1) begin
            rsp_sum_q   <= bus.dp_sum;
            rsp_carry_q <= bus.dp_carry;
            rsp_id_q    <= cur_id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q   <= 4'(DP_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            rsp_sum_q   <= bus.dp_sum;
            rsp_carry_q <= bus.dp_carry;
            rsp_id_q    <= cur_id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      if (latch) begin
        cur_id_q   <= win_id;
        dp_a_q     <= a_arr[win_id];
        dp_b_q     <= b_arr[win_id];
        gnt_q      <= NREQ'(1) << win_id;
        dp_valid_q <= 1'b1;
        busy_q     <= 1'b1;
        state_q    <= GRANT;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.busy      = busy_q;
endmodule
